// File: rtl/wshb_arbiter.sv
// Two-master round-robin Wishbone arbiter: registers a grant, holds it for the
// owner's whole cycle and muxes the owner's request/response path to the slave.
module wshb_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_cyc,
  input  logic                  m0_stb,
  input  logic                  m0_we,
  input  logic [ADDR_W-1:0]     m0_adr,
  input  logic [DATA_W-1:0]     m0_dat_w,
  input  logic [DATA_W/8-1:0]   m0_sel,
  input  logic [2:0]            m0_cti,
  input  logic [1:0]            m0_bte,
  output logic                  m0_ack,
  output logic [DATA_W-1:0]     m0_dat_r,
  input  logic                  m1_cyc,
  input  logic                  m1_stb,
  input  logic                  m1_we,
  input  logic [ADDR_W-1:0]     m1_adr,
  input  logic [DATA_W-1:0]     m1_dat_w,
  input  logic [DATA_W/8-1:0]   m1_sel,
  input  logic [2:0]            m1_cti,
  input  logic [1:0]            m1_bte,
  output logic                  m1_ack,
  output logic [DATA_W-1:0]     m1_dat_r,
  output logic                  s_cyc,
  output logic                  s_stb,
  output logic                  s_we,
  output logic [ADDR_W-1:0]     s_adr,
  output logic [DATA_W-1:0]     s_dat_w,
  output logic [DATA_W/8-1:0]   s_sel,
  output logic [2:0]            s_cti,
  output logic [1:0]            s_bte,
  input  logic                  s_ack,
  input  logic [DATA_W-1:0]     s_dat_r,
  output logic [1:0]            gnt
);

  // Encoding doubles as the one-hot grant vector.
  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] GRANT0 = 2'b01;
  localparam logic [1:0] GRANT1 = 2'b10;

  logic [1:0] state_q, state_d;
  logic       last_q, last_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      GRANT0: begin
        if (!m0_cyc) state_d = m1_cyc ? GRANT1 : IDLE;
      end
      GRANT1: begin
        if (!m1_cyc) state_d = m0_cyc ? GRANT0 : IDLE;
      end
      default: begin
        if (m0_cyc && m1_cyc) state_d = last_q ? GRANT0 : GRANT1;
        else if (m0_cyc)      state_d = GRANT0;
        else if (m1_cyc)      state_d = GRANT1;
        else                  state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (state_d == GRANT0)      last_d = 1'b0;
    else if (state_d == GRANT1) last_d = 1'b1;
  end

  // last resets to 1 so master 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_we    = 1'b0;
    s_adr   = '0;
    s_dat_w = '0;
    s_sel   = '0;
    s_cti   = '0;
    s_bte   = '0;
    case (state_q)
      GRANT0: begin
        s_cyc   = m0_cyc;
        s_stb   = m0_stb;
        s_we    = m0_we;
        s_adr   = m0_adr;
        s_dat_w = m0_dat_w;
        s_sel   = m0_sel;
        s_cti   = m0_cti;
        s_bte   = m0_bte;
      end
      GRANT1: begin
        s_cyc   = m1_cyc;
        s_stb   = m1_stb;
        s_we    = m1_we;
        s_adr   = m1_adr;
        s_dat_w = m1_dat_w;
        s_sel   = m1_sel;
        s_cti   = m1_cti;
        s_bte   = m1_bte;
      end
      default: ;
    endcase
  end

  // Ack follows the registered owner even if it already dropped cyc.
  assign m0_ack   = s_ack && (state_q == GRANT0);
  assign m1_ack   = s_ack && (state_q == GRANT1);
  assign m0_dat_r = s_dat_r;
  assign m1_dat_r = s_dat_r;
  assign gnt      = state_q;

endmodule

// File: tb/tb_wshb_arbiter.sv
// Bench for wshb_arbiter: directed scenarios plus a random phase, all checked
// against an owner/last reference model of the arbitration rules.
module tb_wshb_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [AW-1:0] m0_adr, m1_adr;
  logic [DW-1:0] m0_dat_w, m1_dat_w;
  logic [3:0]    m0_sel, m1_sel;
  logic [2:0]    m0_cti, m1_cti;
  logic [1:0]    m0_bte, m1_bte;
  logic          m0_ack, m1_ack;
  logic [DW-1:0] m0_dat_r, m1_dat_r;
  logic          s_cyc, s_stb, s_we, s_ack;
  logic [AW-1:0] s_adr;
  logic [DW-1:0] s_dat_w, s_dat_r;
  logic [3:0]    s_sel;
  logic [2:0]    s_cti;
  logic [1:0]    s_bte;
  logic [1:0]    gnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: current owner (-1 = nobody) and last master served.
  int own  = -1;
  int last = 1;

  wshb_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
    .m0_dat_w(m0_dat_w), .m0_sel(m0_sel), .m0_cti(m0_cti), .m0_bte(m0_bte),
    .m0_ack(m0_ack), .m0_dat_r(m0_dat_r),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
    .m1_dat_w(m1_dat_w), .m1_sel(m1_sel), .m1_cti(m1_cti), .m1_bte(m1_bte),
    .m1_ack(m1_ack), .m1_dat_r(m1_dat_r),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
    .s_dat_w(s_dat_w), .s_sel(s_sel), .s_cti(s_cti), .s_bte(s_bte),
    .s_ack(s_ack), .s_dat_r(s_dat_r), .gnt(gnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int next_owner(input int o, input int l, input logic c0, input logic c1);
    if (o == 0) return c0 ? 0 : (c1 ? 1 : -1);
    if (o == 1) return c1 ? 1 : (c0 ? 0 : -1);
    if (c0 && c1) return 1 - l;
    if (c0) return 0;
    if (c1) return 1;
    return -1;
  endfunction

  task automatic check_outputs();
    logic [1:0] eg;
    eg = (own == 0) ? 2'b01 : (own == 1) ? 2'b10 : 2'b00;
    chk("gnt", gnt, eg);
    chk("s_cyc", s_cyc, (own == 0) ? m0_cyc : (own == 1) ? m1_cyc : 1'b0);
    chk("s_stb", s_stb, (own == 0) ? m0_stb : (own == 1) ? m1_stb : 1'b0);
    chk("s_we", s_we, (own == 0) ? m0_we : (own == 1) ? m1_we : 1'b0);
    chk("s_adr", s_adr, (own == 0) ? m0_adr : (own == 1) ? m1_adr : '0);
    chk("s_dat_w", s_dat_w, (own == 0) ? m0_dat_w : (own == 1) ? m1_dat_w : '0);
    chk("s_sel", s_sel, (own == 0) ? m0_sel : (own == 1) ? m1_sel : '0);
    chk("s_cti", s_cti, (own == 0) ? m0_cti : (own == 1) ? m1_cti : '0);
    chk("s_bte", s_bte, (own == 0) ? m0_bte : (own == 1) ? m1_bte : '0);
    chk("m0_ack", m0_ack, (own == 0) && s_ack);
    chk("m1_ack", m1_ack, (own == 1) && s_ack);
    chk("m0_dat_r", m0_dat_r, s_dat_r);
    chk("m1_dat_r", m1_dat_r, s_dat_r);
  endtask

  // Called at posedge+1; checks mid-cycle, then advances the model on the edge.
  task automatic tick();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    if (!rst_n) begin
      own  = -1;
      last = 1;
    end else begin
      own = next_owner(own, last, m0_cyc, m1_cyc);
      if (own >= 0) last = own;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    own   = -1;
    last  = 1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic rand_fields();
    m0_adr = $urandom; m0_dat_w = $urandom; m0_sel = 4'($urandom);
    m0_cti = 3'($urandom); m0_bte = 2'($urandom); m0_we = 1'($urandom);
    m0_stb = 1'($urandom);
    m1_adr = $urandom; m1_dat_w = $urandom; m1_sel = 4'($urandom);
    m1_cti = 3'($urandom); m1_bte = 2'($urandom); m1_we = 1'($urandom);
    m1_stb = 1'($urandom);
    s_dat_r = $urandom;
  endtask

  initial begin
    int acks;
    logic [1:0] prev_gnt;
    rst_n = 1'b0;
    {m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we, s_ack} = '0;
    m0_adr = '0; m0_dat_w = '0; m0_sel = '0; m0_cti = '0; m0_bte = '0;
    m1_adr = '0; m1_dat_w = '0; m1_sel = '0; m1_cti = '0; m1_bte = '0;
    s_dat_r = '0;
    @(posedge clk); #1;
    s_ack = 1'b1;
    #1;
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_s_cyc", s_cyc, 1'b0);
    chk("rst_m0_ack", m0_ack, 1'b0);
    chk("rst_m1_ack", m1_ack, 1'b0);
    s_ack = 1'b0;
    do_reset();

    // Single master read burst
    m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 32'h100; m0_sel = 4'hF;
    tick();
    chk("rd_gnt", gnt, 2'b01);
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      s_ack = 1; s_dat_r = 32'hA0 + i;
      #1;
      if (m0_ack) acks++;
      chk("rd_data", m0_dat_r, 32'hA0 + i);
      chk("rd_m1_ack", m1_ack, 1'b0);
      tick();
    end
    chk("rd_acks", acks, 4);
    m0_cyc = 0; m0_stb = 0; s_ack = 0;
    tick();

    // Simultaneous request after reset, then handover
    do_reset();
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    tick();
    chk("tie_gnt", gnt, 2'b01);
    s_ack = 1;
    tick();
    tick();
    m0_cyc = 0; m0_stb = 0; s_ack = 0;
    tick();
    chk("hand_gnt", gnt, 2'b10);
    chk("hand_s_cyc", s_cyc, 1'b1);

    // Continuous requests: strict alternation
    prev_gnt = gnt;
    for (int k = 0; k < 6; k++) begin
      m0_cyc = 1; m1_cyc = 1; m0_stb = 1; m1_stb = 1; s_ack = 1;
      #1;
      chk("alt_gnt", gnt, (k % 2 == 0) ? 2'b10 : 2'b01);
      if (k > 0) chk("alt_change", (gnt != prev_gnt), 1'b1);
      prev_gnt = gnt;
      tick();
      s_ack = 0;
      if (gnt == 2'b01) begin m0_cyc = 0; m0_stb = 0; end
      else begin m1_cyc = 0; m1_stb = 0; end
      tick();
    end
    {m0_cyc, m0_stb, m1_cyc, m1_stb} = '0;
    tick();
    tick();

    // m1 8-beat write burst, m0 requests during beat 3
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_sel = 4'hF; m1_cti = 3'b010;
    m1_dat_w = 32'h11;
    tick();
    chk("wr_gnt", gnt, 2'b10);
    for (int i = 0; i < 8; i++) begin
      m1_dat_w = 32'h11 + i; m1_adr = 32'h200 + 4 * i; s_ack = 1;
      if (i == 2) begin m0_cyc = 1; m0_stb = 1; m0_we = 0; end
      #1;
      chk("wr_dat", s_dat_w, 32'h11 + i);
      chk("wr_m0_ack", m0_ack, 1'b0);
      chk("wr_hold", gnt, 2'b10);
      tick();
    end
    m1_cyc = 0; m1_stb = 0; m1_we = 0; s_ack = 0;
    tick();
    chk("wr_next_gnt", gnt, 2'b01);

    // Asynchronous reset mid-burst
    m1_cyc = 1; m1_stb = 1; s_ack = 1;
    #2;
    rst_n = 0;
    own = -1; last = 1;
    #1;
    chk("arst_gnt", gnt, 2'b00);
    chk("arst_s_cyc", s_cyc, 1'b0);
    chk("arst_m0_ack", m0_ack, 1'b0);
    chk("arst_m1_ack", m1_ack, 1'b0);
    tick();
    rst_n = 1; s_ack = 0;
    tick();
    chk("arst_tie", gnt, 2'b01);

    // Idle bus with spurious slave ack
    {m0_cyc, m0_stb, m1_cyc, m1_stb} = '0;
    tick();
    s_ack = 1;
    #1;
    chk("spur_m0_ack", m0_ack, 1'b0);
    chk("spur_m1_ack", m1_ack, 1'b0);
    chk("spur_s_cyc", s_cyc, 1'b0);
    tick();

    // Random traffic, including acks after the owner drops cyc
    for (int n = 0; n < 400; n++) begin
      rand_fields();
      m0_cyc = m0_cyc ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 3);
      m1_cyc = m1_cyc ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 3);
      s_ack = 1'($urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
